// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the RV32IM inter-stage pipeline registers: control-word layout,
// bubble control value and the per-stage payload widths.
package pipe_stage_buf_pkg;

    localparam int PSB_DATA_W = 128;
    localparam int PSB_CTRL_W = 24;

    localparam logic [PSB_CTRL_W-1:0] PSB_NOP_CTRL = '0;

    localparam int ALU_OP_LSB       = 0;
    localparam int ALU_OP_W         = 5;
    localparam int BRANCH_JUMP_LSB  = 5;
    localparam int BRANCH_JUMP_W    = 3;
    localparam int READ_WRITE_LSB   = 8;
    localparam int READ_WRITE_W     = 4;
    localparam int WB_SEL_LSB       = 12;
    localparam int WB_SEL_W         = 2;
    localparam int REG_WRITE_EN_LSB = 14;
    localparam int DATAMEMSEL_LSB   = 15;
    localparam int DATAMEMSEL_W     = 3;

    // Top bits are spare so later stages can grow the control word without re-layout.
    typedef struct packed {
        logic [5:0] rsvd;
        logic [2:0] datamemsel;
        logic       reg_write_en;
        logic [1:0] wb_sel;
        logic [3:0] read_write;
        logic [2:0] branch_jump;
        logic [4:0] alu_op;
    } ctrl_t;

    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 24;
    localparam int IDEX_DATA_W  = 128;
    localparam int IDEX_CTRL_W  = 24;
    localparam int EXMEM_DATA_W = 96;
    localparam int EXMEM_CTRL_W = 24;
    localparam int MEMWB_DATA_W = 64;
    localparam int MEMWB_CTRL_W = 24;

    function automatic logic ctrl_reg_write_en(input logic [PSB_CTRL_W-1:0] c);
        return c[REG_WRITE_EN_LSB];
    endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One pipeline entry: valid bit plus payload register with load, clear and async reset.
module pipe_stage_buf_slot
    import pipe_stage_buf_pkg::*;
#(
    parameter int W = PSB_DATA_W + PSB_CTRL_W
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear only drops the valid bit; the payload keeps its last value.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end
            if (i_load && !i_clear) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer
// (registered in_ready) and flush that turns every held entry into a bubble.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                DATA_W   = PSB_DATA_W,
    parameter int                CTRL_W   = PSB_CTRL_W,
    parameter int                SKID     = 1,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int PW = DATA_W + CTRL_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HEAD  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_in_ready;
    logic          r_live;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_head_load;
    logic          w_head_clr;
    logic          w_skid_load;
    logic          w_skid_clr;
    logic          w_head_vld;
    logic          w_skid_vld;
    logic [PW-1:0] w_in_pl;
    logic [PW-1:0] w_head_d;
    logic [PW-1:0] w_head_q;
    logic [PW-1:0] w_skid_q;

    assign w_in_pl    = {in_ctrl, in_data};
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_head_vld & out_ready;

    // Flush overrides everything, including an input transfer in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_head_load = 1'b0;
        w_head_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        if (flush) begin
            w_head_clr  = 1'b1;
            w_skid_clr  = 1'b1;
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_head_load = 1'b1;
                        w_state_nxt = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (w_in_fire && w_out_fire) begin
                        w_head_load = 1'b1;
                    end else if (w_in_fire && (SKID != 0)) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_head_clr  = 1'b1;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_head_load = 1'b1;
                        w_skid_clr  = 1'b1;
                        w_state_nxt = ST_HEAD;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
            r_live     <= 1'b1;
        end
    end

    // Skid entry only ever feeds the head, and only when it is occupied.
    assign w_head_d = w_skid_vld ? w_skid_q : w_in_pl;

    pipe_stage_buf_slot #(.W(PW)) u_head (
        .clk     (clk),
        .i_rst_n (reset),
        .i_load  (w_head_load),
        .i_clear (w_head_clr),
        .i_data  (w_head_d),
        .o_valid (w_head_vld),
        .o_data  (w_head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_buf_slot #(.W(PW)) u_skid (
                .clk     (clk),
                .i_rst_n (reset),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clr),
                .i_data  (w_in_pl),
                .o_valid (w_skid_vld),
                .o_data  (w_skid_q)
            );
        end else begin : g_noskid
            logic w_unused_skid;
            assign w_unused_skid = w_skid_load | w_skid_clr;
            assign w_skid_vld    = 1'b0;
            assign w_skid_q      = '0;
        end
    endgenerate

    assign in_ready  = (SKID != 0) ? r_in_ready : (r_live & (~w_head_vld | out_ready));
    assign out_valid = w_head_vld;
    assign out_data  = w_head_q[DATA_W-1:0];
    assign out_ctrl  = w_head_vld ? w_head_q[PW-1:DATA_W] : NOP_CTRL;
    assign occupancy = r_state;

endmodule
